// File: rtl/mac_pkg.sv
// Shared MAC result-path definitions: default tile geometry,
// serializer state encoding and the row-major element index helper.
package mac_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ROWS       = 4;
    localparam int DEF_COLS       = 4;
    localparam int DEF_LANES      = 2;

    localparam int BEATS_PER_ROW = DEF_COLS / DEF_LANES;
    localparam int TILE_BEATS    = DEF_ROWS * BEATS_PER_ROW;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int unsigned idx(
        input int unsigned r,
        input int unsigned c,
        input int unsigned cols
    );
        return r * cols + c;
    endfunction

endpackage

// File: rtl/mac_result_serializer.sv
// Captures one MAC result tile and streams it out LANES elements per
// beat with row/tile framing, freeing the MAC right after capture.
import mac_pkg::*;

module mac_result_serializer #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int LANES      = DEF_LANES
) (
    input  logic                                     clk_p,
    input  logic                                     rst_n,
    input  logic [DATA_WIDTH*ROWS*COLS-1:0]          tile_in,
    input  logic                                     tile_valid,
    output logic                                     tile_ready,
    output logic [DATA_WIDTH*LANES-1:0]              out_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] out_row,
    output logic                                     out_last_row,
    output logic                                     out_last,
    output logic                                     busy
);

    localparam int TW        = DATA_WIDTH * ROWS * COLS;
    localparam int LW        = DATA_WIDTH * LANES;
    localparam int ROW_BEATS = COLS / LANES;
    localparam int RW        = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int BW        = ROW_BEATS > 1 ? $clog2(ROW_BEATS) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(ROW_BEATS - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

    generate
        if (LANES < 1 || COLS % LANES != 0) begin : g_bad_geometry
            $fatal(1, "COLS must be a non-zero multiple of LANES");
        end
    endgenerate

    state_t          r_state;
    logic [TW-1:0]   r_buf;
    logic [RW-1:0]   r_row;
    logic [BW-1:0]   r_beat;

    logic            w_send;
    logic            w_row_end;
    logic            w_tile_end;
    int unsigned     w_base;

    assign w_send     = (r_state == SEND);
    assign w_row_end  = (r_beat == LAST_BEAT);
    assign w_tile_end = w_row_end && (r_row == LAST_ROW);

    always_comb begin
        w_base = idx(32'(r_row), 32'(r_beat) * LANES, COLS) * DATA_WIDTH;
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_row   <= '0;
            r_beat  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (tile_valid) begin
                        r_buf   <= tile_in;
                        r_row   <= '0;
                        r_beat  <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (w_row_end) begin
                            r_beat <= '0;
                            if (w_tile_end) begin
                                r_row   <= '0;
                                r_state <= IDLE;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Flags are qualified by SEND so a single-beat row cannot flag in IDLE.
    assign tile_ready   = !w_send;
    assign out_valid    = w_send;
    assign busy         = w_send;
    assign out_data     = r_buf[w_base +: LW];
    assign out_row      = r_row;
    assign out_last_row = w_send && w_row_end;
    assign out_last     = w_send && w_tile_end;

endmodule

// File: tb/tb_mac_result_serializer.sv
// Directed bench for mac_result_serializer: default 4x4x2 instance
// plus a 1x4x4 single-beat instance.
module tb_mac_result_serializer;

    logic         clk_p = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] tile_in = '0;
    logic         tile_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         tile_ready;
    logic [15:0]  out_data;
    logic         out_valid;
    logic [1:0]   out_row;
    logic         out_last_row;
    logic         out_last;
    logic         busy;

    logic [31:0]  s_tile = '0;
    logic         s_valid = 1'b0;
    logic         s_oready = 1'b1;
    logic         s_tready;
    logic [31:0]  s_data;
    logic         s_ovalid;
    logic [0:0]   s_row;
    logic         s_lr;
    logic         s_last;
    logic         s_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk_p = ~clk_p;

    mac_result_serializer u_dut (
        .clk_p        (clk_p),
        .rst_n        (rst_n),
        .tile_in      (tile_in),
        .tile_valid   (tile_valid),
        .tile_ready   (tile_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_last_row (out_last_row),
        .out_last     (out_last),
        .busy         (busy)
    );

    mac_result_serializer #(
        .DATA_WIDTH (8),
        .ROWS       (1),
        .COLS       (4),
        .LANES      (4)
    ) u_sweep (
        .clk_p        (clk_p),
        .rst_n        (rst_n),
        .tile_in      (s_tile),
        .tile_valid   (s_valid),
        .tile_ready   (s_tready),
        .out_data     (s_data),
        .out_valid    (s_ovalid),
        .out_ready    (s_oready),
        .out_row      (s_row),
        .out_last_row (s_lr),
        .out_last     (s_last),
        .busy         (s_busy)
    );

    function automatic logic [127:0] mk_tile(input int base);
        logic [127:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) t[i*8 +: 8] = 8'(base + i);
        return t;
    endfunction

    function automatic logic [15:0] exp_beat(input int base, input int k);
        return {8'(base + 2*k + 1), 8'(base + 2*k)};
    endfunction

    // Starts and ends on a negedge; leaves the first beat visible.
    task automatic capture(input logic [127:0] t);
        tile_in    = t;
        tile_valid = 1'b1;
        @(negedge clk_p);
        tile_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk_p);
        checks++;
        if (tile_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs got rdy=%b vld=%b busy=%b exp 1 0 0",
                     tile_ready, out_valid, busy);
        end
        checks++;
        if (out_data !== 16'h0000 || out_row !== 2'd0) begin
            errors++;
            $display("FAIL reset_data got data=%h row=%0d exp 0000 0",
                     out_data, out_row);
        end
        checks++;
        if (out_last_row !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got lr=%b last=%b exp 0 0",
                     out_last_row, out_last);
        end
        checks++;
        if (s_tready !== 1'b1 || s_ovalid !== 1'b0 || s_lr !== 1'b0 || s_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_sweep got rdy=%b vld=%b lr=%b last=%b exp 1 0 0 0",
                     s_tready, s_ovalid, s_lr, s_last);
        end
        rst_n = 1'b1;
        @(negedge clk_p);
    endtask

    task automatic test_stream;
        out_ready = 1'b1;
        capture(mk_tile(0));
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_beat(0, k) ||
                out_row !== 2'(k / 2)) begin
                errors++;
                $display("FAIL stream_beat k=%0d got vld=%b data=%h row=%0d exp 1 %h %0d",
                         k, out_valid, out_data, out_row, exp_beat(0, k), k / 2);
            end
            checks++;
            if (out_last_row !== 1'((k % 2) == 1) || out_last !== 1'(k == 7) ||
                tile_ready !== 1'b0) begin
                errors++;
                $display("FAIL stream_flags k=%0d got lr=%b last=%b rdy=%b exp %b %b 0",
                         k, out_last_row, out_last, tile_ready, (k % 2) == 1, k == 7);
            end
            @(negedge clk_p);
        end
        checks++;
        if (tile_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_done got rdy=%b vld=%b busy=%b exp 1 0 0",
                     tile_ready, out_valid, busy);
        end
    endtask

    task automatic test_backpressure;
        int k;
        k = 0;
        out_ready = 1'b0;
        capture(mk_tile(0));
        for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
            out_ready = 1'(cyc % 2);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_beat(0, k) ||
                out_row !== 2'(k / 2) || out_last_row !== 1'((k % 2) == 1) ||
                out_last !== 1'(k == 7)) begin
                errors++;
                $display("FAIL bp_beat k=%0d got vld=%b data=%h row=%0d lr=%b last=%b exp data=%h",
                         k, out_valid, out_data, out_row, out_last_row, out_last,
                         exp_beat(0, k));
            end
            if (out_valid && out_ready) k++;
            @(negedge clk_p);
        end
        out_ready = 1'b1;
        checks++;
        if (k !== 8 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_count got transfers=%0d vld=%b exp 8 0", k, out_valid);
        end
    endtask

    task automatic test_signed;
        out_ready = 1'b1;
        capture({16{8'h80}});
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h8080) begin
                errors++;
                $display("FAIL signed_beat k=%0d got vld=%b data=%h exp 1 8080",
                         k, out_valid, out_data);
            end
            @(negedge clk_p);
        end
    endtask

    task automatic test_back_to_back;
        out_ready  = 1'b1;
        tile_in    = mk_tile(0);
        tile_valid = 1'b1;
        @(negedge clk_p);
        tile_in = mk_tile(100);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_beat(0, k) || tile_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_first k=%0d got vld=%b data=%h rdy=%b exp 1 %h 0",
                         k, out_valid, out_data, tile_ready, exp_beat(0, k));
            end
            @(negedge clk_p);
        end
        checks++;
        if (tile_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got rdy=%b vld=%b exp 1 0", tile_ready, out_valid);
        end
        @(negedge clk_p);
        tile_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h6564 || out_row !== 2'd0) begin
            errors++;
            $display("FAIL b2b_second got vld=%b data=%h row=%0d exp 1 6564 0",
                     out_valid, out_data, out_row);
        end
        for (int k = 1; k < 8; k++) begin
            @(negedge clk_p);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_beat(100, k)) begin
                errors++;
                $display("FAIL b2b_drain k=%0d got vld=%b data=%h exp 1 %h",
                         k, out_valid, out_data, exp_beat(100, k));
            end
        end
        @(negedge clk_p);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        capture(mk_tile(0));
        repeat (3) @(negedge clk_p);
        checks++;
        if (out_data !== exp_beat(0, 3)) begin
            errors++;
            $display("FAIL mid_pre got data=%h exp %h", out_data, exp_beat(0, 3));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || tile_ready !== 1'b1 || busy !== 1'b0 ||
            out_data !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset got vld=%b rdy=%b busy=%b data=%h exp 0 1 0 0000",
                     out_valid, tile_ready, busy, out_data);
        end
        @(negedge clk_p);
        rst_n = 1'b1;
        @(negedge clk_p);
        checks++;
        if (out_valid !== 1'b0 || tile_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_release got vld=%b rdy=%b exp 0 1", out_valid, tile_ready);
        end
        capture(mk_tile(100));
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h6564 || out_row !== 2'd0) begin
            errors++;
            $display("FAIL mid_restart got vld=%b data=%h row=%0d exp 1 6564 0",
                     out_valid, out_data, out_row);
        end
        repeat (8) @(negedge clk_p);
        checks++;
        if (out_valid !== 1'b0 || tile_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_drain got vld=%b rdy=%b exp 0 1", out_valid, tile_ready);
        end
    endtask

    task automatic test_sweep;
        s_oready = 1'b1;
        s_tile   = 32'h44332211;
        s_valid  = 1'b1;
        @(negedge clk_p);
        s_valid = 1'b0;
        checks++;
        if (s_ovalid !== 1'b1 || s_data !== 32'h44332211 || s_row !== 1'b0) begin
            errors++;
            $display("FAIL sweep_beat got vld=%b data=%h row=%0d exp 1 44332211 0",
                     s_ovalid, s_data, s_row);
        end
        checks++;
        if (s_lr !== 1'b1 || s_last !== 1'b1) begin
            errors++;
            $display("FAIL sweep_flags got lr=%b last=%b exp 1 1", s_lr, s_last);
        end
        @(negedge clk_p);
        checks++;
        if (s_ovalid !== 1'b0 || s_tready !== 1'b1) begin
            errors++;
            $display("FAIL sweep_done got vld=%b rdy=%b exp 0 1", s_ovalid, s_tready);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_signed;
        test_back_to_back;
        test_reset_mid;
        test_sweep;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
